// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the eight-digit seven-segment scan controller.
// Segment patterns are active-low, bit order a..g (bit 6 = a, bit 0 = g).
package seg_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] DIG_OFF = 8'hFF;

  // Indexed by the hex nibble value; entry 15 is written first.
  localparam logic [15:0][6:0] SEG_PAT = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  // Load handshake: idle means a new value may be accepted.
  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_PEND = 1'b1
  } load_state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low a..g segment pattern.
module seg_hex_decode
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_PAT[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed eight-digit seven-segment scanner with a frame-synchronised
// display load, so a new value never appears partway through a frame.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  input  logic [7:0]  dp,
  input  logic [7:0]  blank_mask,
  output logic [7:0]  led_id,
  output logic [7:0]  out_led,
  output logic        frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   disp;
  logic [31:0]   pending;
  logic          tick;
  logic          boundary;
  logic [6:0]    seg;

  load_state_e   state;
  load_state_e   state_nxt;
  logic          capture;
  logic          commit;

  assign tick     = (cnt == CNT_MAX);
  assign boundary = tick && (idx == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx + 3'd1;
    end
  end

  // Handshake: a load transfers on any edge where wr_en && wr_ready.
  // wr_ready drops the next cycle and rises again the cycle after the
  // first frame boundary that follows the transfer edge.
  assign wr_ready = (state == LD_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= LD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    commit    = 1'b0;
    case (state)
      LD_IDLE: begin
        if (wr_en) begin
          capture   = 1'b1;
          state_nxt = LD_PEND;
        end
      end
      LD_PEND: begin
        if (boundary) begin
          commit    = 1'b1;
          state_nxt = LD_IDLE;
        end
      end
      default: state_nxt = LD_IDLE;
    endcase
  end

  // A capture on a boundary edge leaves the FSM idle for that edge, so the
  // value waits for the following boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      disp    <= '0;
    end else begin
      if (capture) pending <= wr_data;
      if (commit)  disp    <= pending;
    end
  end

  seg_hex_decode u_dec (
    .nibble (disp[{idx, 2'b00} +: 4]),
    .seg    (seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      led_id     <= DIG_OFF;
      out_led    <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      if ((cnt < BLANK_END) || blank_mask[idx]) led_id <= DIG_OFF;
      else                                      led_id <= ~(8'b1 << idx);
      out_led    <= {seg, ~dp[idx]};
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-level reference model, directed scenarios
// with literal expectations, then randomized traffic.
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME     = SCAN_DIV * 8;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [7:0]  dp = '0;
  logic [7:0]  blank_mask = '0;
  logic        wr_ready;
  logic [7:0]  led_id;
  logic [7:0]  out_led;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .dp         (dp),
    .blank_mask (blank_mask),
    .led_id     (led_id),
    .out_led    (out_led),
    .frame_done (frame_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // Scoreboard: {led_id, out_led, frame_done, wr_ready} expected after each edge
  logic [17:0] exp_q[$];

  // Reference model: time since reset drives slot position arithmetically
  initial begin : model
    int          m_t;
    logic [31:0] m_disp;
    logic [31:0] m_pend;
    bit          m_has;
    bit          started;
    int          cnt;
    int          di;
    bit          bnd;
    bit          ready_pre;
    logic [7:0]  e_led;
    logic [7:0]  e_out;
    logic [3:0]  nib;
    started = 0;
    m_t = 0; m_disp = '0; m_pend = '0; m_has = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        started = 1;
        m_t = 0; m_disp = '0; m_pend = '0; m_has = 0;
        exp_q.push_back({8'hFF, 8'hFF, 1'b0, 1'b1});
      end else if (started) begin
        cnt = m_t % SCAN_DIV;
        di  = (m_t / SCAN_DIV) % 8;
        bnd = (cnt == SCAN_DIV - 1) && (di == 7);
        if (cnt < BLANK_CYC || blank_mask[di]) e_led = 8'hFF;
        else                                   e_led = ~(8'h01 << di);
        nib   = m_disp[4*di +: 4];
        e_out = {hex_seg(nib), ~dp[di]};
        ready_pre = !m_has;
        if (m_has && bnd) begin
          m_disp = m_pend;
          m_has  = 0;
        end
        if (wr_en && ready_pre) begin
          m_pend = wr_data;
          m_has  = 1;
        end
        exp_q.push_back({e_led, e_out, bnd, !m_has});
        m_t++;
      end
    end
  end

  // Compare process
  initial begin : compare
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("led_id", led_id, e[17:10]);
        check("out_led", out_led, e[9:2]);
        check("frame_done", frame_done, e[1]);
        check("wr_ready", wr_ready, e[0]);
        check("one_digit_lit", $countones(~led_id) <= 1, 1);
      end
    end
  end

  // Driver / wait tasks
  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 2 * FRAME);
    check("wait_frame_done", frame_done, 1);
  endtask

  task automatic wait_digit(input int d, output logic [7:0] o);
    logic [7:0] target;
    int n = 0;
    target = ~(8'h01 << d);
    do begin
      @(negedge clk);
      n++;
    end while (led_id !== target && n < 2 * FRAME);
    check("wait_digit", led_id, target);
    o = out_led;
  endtask

  initial begin : main
    logic [7:0] o;
    int cnt7f;
    int fd_cnt;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Blank display scan, literal timeline from reset release
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      case (k)
        0:  check("s1_led_c0", led_id, 8'hFF);
        1: begin
          check("s1_led_c1", led_id, 8'hFE);
          check("s1_out_c1", out_led, 8'h03);
        end
        4:  check("s1_led_c4", led_id, 8'hFF);
        5:  check("s1_led_c5", led_id, 8'hFD);
        28: check("s1_led_c28", led_id, 8'hFF);
        29: check("s1_led_c29", led_id, 8'h7F);
        30: check("s1_fd_c30", frame_done, 0);
        31: check("s1_fd_c31", frame_done, 1);
        default: ;
      endcase
    end

    // Simple load
    wr_en = 1'b1; wr_data = 32'h01234567;
    @(negedge clk);
    wr_en = 1'b0;
    check("s2_ready_low", wr_ready, 0);
    wait_fd();
    check("s2_ready_back", wr_ready, 1);
    wait_digit(0, o); check("s2_dig0", o, 8'h1F);
    wait_digit(7, o); check("s2_dig7", o, 8'h03);

    // Second write while busy is ignored
    wait_fd();
    repeat (3) @(negedge clk);
    wr_en = 1'b1; wr_data = 32'hFEDCBA98;
    @(negedge clk);
    wr_data = 32'h11111111;
    @(negedge clk);
    wr_en = 1'b0;
    check("s3_ready_low", wr_ready, 0);
    wait_fd();
    wait_digit(0, o); check("s3_dig0", o, 8'h01);
    wait_digit(7, o); check("s3_dig7", o, 8'h71);

    // Write landing exactly on the boundary edge
    wait_fd();
    repeat (FRAME - 1) @(negedge clk);
    wr_en = 1'b1; wr_data = 32'h00000002;
    @(negedge clk);
    wr_en = 1'b0;
    check("s4_fd_at_write", frame_done, 1);
    check("s4_ready_low", wr_ready, 0);
    wait_digit(0, o); check("s4_dig0_old", o, 8'h01);
    wait_fd();
    wait_digit(0, o); check("s4_dig0_new", o, 8'h25);
    fd_cnt = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
    end
    check("s4_fd_per_64", fd_cnt, 2);

    // Blank mask and decimal point
    blank_mask = 8'h80; dp = 8'h01;
    cnt7f = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (led_id == 8'h7F) cnt7f++;
    end
    check("s5_no_digit7", cnt7f, 0);
    wait_digit(0, o);
    check("s5_dp_bit", o[0], 0);
    check("s5_dig0", o, 8'h24);
    blank_mask = 8'h00; dp = 8'h00;

    // Reset with a load pending
    wait_fd();
    repeat (10) @(negedge clk);
    wr_en = 1'b1; wr_data = 32'h12345678;
    @(negedge clk);
    wr_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s6_led_rst", led_id, 8'hFF);
    check("s6_out_rst", out_led, 8'hFF);
    check("s6_ready_rst", wr_ready, 1);
    check("s6_fd_rst", frame_done, 0);
    wait_digit(0, o); check("s6_dig0", o, 8'h03);
    wait_fd();
    wait_digit(3, o); check("s6_dig3", o, 8'h03);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      wr_en   = ($urandom_range(0, 9) == 0);
      wr_data = $urandom;
      if ($urandom_range(0, 49) == 0) dp = 8'($urandom);
      if ($urandom_range(0, 49) == 0) blank_mask = 8'($urandom);
      rst = ($urandom_range(0, 499) == 0);
    end
    wr_en = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles per digit slot (min 4).
REQ-002 SHALL have parameter BLANK_CYC, default 4, inter-digit blanking cycles at the start of each slot (1 <= BLANK_CYC < SCAN_DIV).
REQ-003 SHALL have port clk  in  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  in  1  load request for a new display value.
REQ-006 SHALL have port wr_data  in  32  eight hex nibbles; digit i = wr_data[4i+3:4i].
REQ-007 SHALL have port wr_ready  out  1  high when a load is accepted.
REQ-008 SHALL have port dp  in  8  dp[i]=1 lights the decimal point of digit i (sampled live).
REQ-009 SHALL have port blank_mask  in  8  blank_mask[i]=1 keeps digit i dark (sampled live).
REQ-010 SHALL have port led_id  out  8  active-low digit enables; bit i = digit i, registered.
REQ-011 SHALL have port out_led  out  8  active-low segments, bits 7..0 = a,b,c,d,e,f,g,dp, registered.
REQ-012 SHALL have port frame_done  out  1  one-cycle pulse when digit 7's slot ends.

Function
REQ-013 Prescaler cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; tick = (cnt == SCAN_DIV-1).
REQ-014 Digit index idx (3 bits) SHALL increment on tick, wrapping 7->0; frame boundary = tick with idx==7.
REQ-015 frame_done SHALL be high in the cycle after the frame boundary cycle, for exactly one cycle.
REQ-016 Handshake: wr_en && wr_ready SHALL capture wr_data into a pending register; wr_ready is low from the next cycle on.
REQ-017 At the first frame boundary strictly after capture, pending SHALL copy to display register disp; wr_ready returns high the cycle after.
REQ-018 wr_en while wr_ready is low SHALL be ignored; the pending value is unchanged.
REQ-019 A capture in a frame boundary cycle SHALL apply at the next boundary, not the current one (no tearing mid-frame).
REQ-020 Outputs SHALL be registered from the current cnt/idx/disp: one cycle latency.
REQ-021 If cnt < BLANK_CYC or blank_mask[idx]=1, the next led_id SHALL be 8'hFF; otherwise led_id = ~(8'b1 << idx).
REQ-022 out_led[7:1] SHALL be the segment pattern of nibble idx of disp, and out_led[0] = ~dp[idx].
REQ-023 Segment patterns (a..g, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-024 Exactly zero or one led_id bit SHALL be low in any cycle.

Reset
REQ-025 rst SHALL set cnt=0, idx=0, disp=0, pending=0, wr_ready=1, frame_done=0, led_id=8'hFF, out_led=8'hFF on the next edge.
REQ-026 rst during a pending load SHALL discard it; disp stays 0.
REQ-027 Outputs SHALL be defined only by reset values until the first post-reset edge updates them.

Structure
REQ-028 A shared package SHALL hold NUM_DIGITS=8, the 16-entry segment pattern constants, and the all-off constants SEG_OFF=8'hFF and DIG_OFF=8'hFF.
REQ-029 The combinational nibble-to-segment table SHALL be one sub-module, seg_hex_decode (4-bit in, 7-bit out).
REQ-030 The prescaler, digit index, load handshake and output registers SHALL live in seg_scan_ctrl itself.

Verification (SCAN_DIV=4, BLANK_CYC=1)
REQ-031 Reset, no write -> led_id cycles FE,FD,...,7F; out_led=8'h03 whenever a digit is lit; 8'hFF in the first cycle of each slot.
REQ-032 Write 32'h01234567, wait one frame -> digit 0 out_led=8'h1F, digit 7 out_led=8'h03; wr_ready low until 1 cycle after the boundary.
REQ-033 Write 32'hFEDCBA98; second write 32'h11111111 while wr_ready=0 -> the second write is ignored, digit 0=8'h01, digit 7=8'h71.
REQ-034 Write asserted exactly in the boundary cycle -> disp is unchanged for one full frame, then updates; frame_done pulses once per 32 cycles.
REQ-035 blank_mask=8'h80, dp=8'h01 -> led_id never 7F; digit 0 out_led[0]=0.
REQ-036 rst asserted mid-frame with a load pending -> next cycle led_id=8'hFF, wr_ready=1, and the display shows all zeros afterwards.
